// File: rtl/score_scan_display.sv
// score_scan_display: saturating BCD score accumulator with multiplexed active-low seven-segment scan; define SCORE_LZB_EN for leading-zero blanking
module score_scan_display #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100000,
   parameter int POINTS_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                add_valid,
   input  logic [POINTS_W-1:0] add_points,
   output logic                add_ready,
   input  logic                clear,
   output logic [4*DIGITS-1:0] score_bcd,
   output logic                saturated,
   output logic [DIGITS-1:0]   an,
   output logic [6:0]          seg
);
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic [4*DIGITS-1:0] score_q, score_d, score_inc;
   logic [POINTS_W-1:0] pending_q, pending_d;
   logic                sat_q, sat_d, all_nines;
   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic [3:0]          cur_digit;
   logic                blank, tick;

   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0: enc = 7'b1000000;
         4'd1: enc = 7'b1111001;
         4'd2: enc = 7'b0100100;
         4'd3: enc = 7'b0110000;
         4'd4: enc = 7'b0011001;
         4'd5: enc = 7'b0010010;
         4'd6: enc = 7'b0000010;
         4'd7: enc = 7'b1111000;
         4'd8: enc = 7'b0000000;
         4'd9: enc = 7'b0010000;
         default: enc = 7'h7F;
      endcase
   endfunction

   assign add_ready = (pending_q == '0);
   assign score_bcd = score_q;
   assign saturated = sat_q;
   assign an        = an_q;
   assign seg       = seg_q;
   assign tick      = (presc_q == PW'(SCAN_DIV - 1));

   // score plus one with BCD ripple carry; all_nines is the carry out of the top digit
   always_comb begin
      score_inc = score_q;
      all_nines = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (all_nines) begin
            score_inc[4*i +: 4] = (score_q[4*i +: 4] == 4'd9) ? 4'd0 : score_q[4*i +: 4] + 4'd1;
            all_nines = (score_q[4*i +: 4] == 4'd9);
         end
      end
   end

   // award accept/drain; clear wins over both, and an increment at all-nines is dropped and flagged
   always_comb begin
      score_d   = score_q;
      pending_d = pending_q;
      sat_d     = sat_q;
      if (clear) begin
         score_d   = '0;
         pending_d = '0;
         sat_d     = 1'b0;
      end else if (pending_q != '0) begin
         pending_d = pending_q - 1'b1;
         score_d   = all_nines ? score_q : score_inc;
         sat_d     = sat_q | all_nines;
      end else if (add_valid) begin
         pending_d = add_points;
      end
   end

   // select the digit being scanned; idx 0 is the most-significant digit
   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < DIGITS; i++)
         if (i == int'(idx_q)) cur_digit = score_q[4*(DIGITS-1-i) +: 4];
   end

`ifdef SCORE_LZB_EN
   // blank while this digit and everything to its left are zero; the rightmost digit always shows
   always_comb begin
      blank = (int'(idx_q) != DIGITS - 1);
      for (int i = 0; i < DIGITS; i++)
         if (i <= int'(idx_q) && score_q[4*(DIGITS-1-i) +: 4] != 4'd0) blank = 1'b0;
   end
`else
   assign blank = 1'b0;
`endif

   // prescaler and digit scan; anodes and segments update together on each tick
   always_comb begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = !tick ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      an_d    = tick ? ~(DIGITS'(1) << (DIGITS - 1 - int'(idx_q))) : an_q;
      seg_d   = !tick ? seg_q : blank ? 7'h7F : enc(cur_digit);
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         score_q   <= '0;
         pending_q <= '0;
         sat_q     <= 1'b0;
         presc_q   <= '0;
         idx_q     <= '0;
         an_q      <= '1;
         seg_q     <= 7'h7F;
      end else begin
         score_q   <= score_d;
         pending_q <= pending_d;
         sat_q     <= sat_d;
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end
endmodule

// File: tb/tb_score_scan_display.sv
// tb_score_scan_display: directed and random stimulus against an integer-arithmetic score/scan model
module tb_score_scan_display;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int POINTS_W = 4;
   localparam int MAXS     = 9999;

   logic                clk = 1'b0, rst = 1'b1, add_valid = 1'b0, clear = 1'b0;
   logic [POINTS_W-1:0] add_points = '0;
   logic                add_ready, saturated;
   logic [15:0]         score_bcd;
   logic [3:0]          an;
   logic [6:0]          seg;

   int         vecs = 0, fails = 0;
   int         m_score = 0, m_pend = 0, m_cyc = 0;
   logic       m_sat = 1'b0;
   logic [3:0] m_an = 4'hF;
   logic [6:0] m_seg = 7'h7F;
   logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   logic [3:0] exp_an [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
`ifdef SCORE_LZB_EN
   logic [6:0] exp_seg [4] = '{7'h7F, 7'b0110000, 7'b1000000, 7'b0010010};
`else
   logic [6:0] exp_seg [4] = '{7'b1000000, 7'b0110000, 7'b1000000, 7'b0010010};
`endif

   always #5 clk = ~clk;

   score_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .POINTS_W(POINTS_W)) dut (
      .clk(clk), .rst(rst), .add_valid(add_valid), .add_points(add_points), .add_ready(add_ready),
      .clear(clear), .score_bcd(score_bcd), .saturated(saturated), .an(an), .seg(seg)
   );

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int ns = m_score, np = m_pend, nc = m_cyc, d, v;
      logic nsat = m_sat;
      logic [3:0] nan = m_an;
      logic [6:0] nseg = m_seg;
      bit bl;
      if (rst) begin
         ns = 0; np = 0; nsat = 1'b0; nc = 0; nan = 4'hF; nseg = 7'h7F;
      end else begin
         nc = m_cyc + 1;
         if (nc % SCAN_DIV == 0) begin
            d = (nc / SCAN_DIV - 1) % DIGITS;
            v = (m_score / (10 ** (DIGITS - 1 - d))) % 10;
`ifdef SCORE_LZB_EN
            bl = (d != DIGITS - 1) && (m_score < 10 ** (DIGITS - 1 - d));
`else
            bl = 1'b0;
`endif
            nseg = bl ? 7'h7F : segtab[v];
            nan = 4'hF;
            nan[DIGITS - 1 - d] = 1'b0;
         end
         if (clear) begin
            ns = 0; np = 0; nsat = 1'b0;
         end else if (m_pend != 0) begin
            np = m_pend - 1;
            if (m_score == MAXS) nsat = 1'b1;
            else ns = m_score + 1;
         end else if (add_valid) begin
            np = int'(add_points);
         end
      end
      @(posedge clk);
      #1;
      m_score = ns; m_pend = np; m_cyc = nc; m_sat = nsat; m_an = nan; m_seg = nseg;
      check("score", 32'(score_bcd), 32'(to_bcd(m_score)));
      check("ready", 32'(add_ready), 32'(m_pend == 0));
      check("sat", 32'(saturated), 32'(m_sat));
      check("an", 32'(an), 32'(m_an));
      check("seg", 32'(seg), 32'(m_seg));
   endtask

   task automatic award(input int p);
      add_valid = 1'b1;
      add_points = POINTS_W'(p);
      step();
      add_valid = 1'b0;
      for (int k = 0; k < 20 && m_pend != 0; k++) step();
   endtask

   initial begin
      int guard;
      rst = 1'b1;
      step();
      step();
      check("rst_an", 32'(an), 32'h0F);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_score", 32'(score_bcd), 32'h0000);
      check("rst_ready", 32'(add_ready), 32'h1);
      check("rst_sat", 32'(saturated), 32'h0);
      rst = 1'b0;

      add_valid = 1'b1;
      add_points = 4'd7;
      step();
      check("hs_busy_e0", 32'(add_ready), 32'h0);
      add_points = 4'd5;
      repeat (6) begin
         step();
         check("hs_busy", 32'(add_ready), 32'h0);
      end
      step();
      check("hs_ready_e7", 32'(add_ready), 32'h1);
      step();
      check("hs_accept_e8", 32'(add_ready), 32'h0);
      repeat (5) step();
      add_valid = 1'b0;
      check("hs_score12", 32'(score_bcd), 32'h0012);

      while (m_score < 999) award((999 - m_score) < 15 ? (999 - m_score) : 15);
      check("carry_999", 32'(score_bcd), 32'h0999);
      add_valid = 1'b1;
      add_points = 4'd1;
      step();
      add_valid = 1'b0;
      step();
      check("carry_1000", 32'(score_bcd), 32'h1000);

      clear = 1'b1;
      step();
      clear = 1'b0;
      award(15);
      award(15);
      award(10);
      add_valid = 1'b1;
      add_points = 4'd4;
      step();
      add_valid = 1'b0;
      step();
      step();
      check("clr_pre42", 32'(score_bcd), 32'h0042);
      check("clr_pre_busy", 32'(add_ready), 32'h0);
      clear = 1'b1;
      add_valid = 1'b1;
      add_points = 4'd3;
      step();
      clear = 1'b0;
      add_valid = 1'b0;
      check("clr_score", 32'(score_bcd), 32'h0000);
      check("clr_ready", 32'(add_ready), 32'h1);
      step();
      check("clr_ignored", 32'(score_bcd), 32'h0000);

      repeat (20) award(15);
      award(5);
      check("scan_305", 32'(score_bcd), 32'h0305);
      repeat (16) step();
      for (int k = 0; k < 16 && m_cyc % 16 != 4; k++) step();
      for (int d = 0; d < 4; d++) begin
         repeat (4) begin
            check("scan_an", 32'(an), 32'(exp_an[d]));
            check("scan_seg", 32'(seg), 32'(exp_seg[d]));
            step();
         end
      end

      repeat (300) begin
         add_valid = 1'($urandom_range(0, 1));
         add_points = POINTS_W'($urandom);
         clear = ($urandom_range(0, 19) == 0);
         step();
      end
      clear = 1'b0;
      add_valid = 1'b0;
      for (int k = 0; k < 20 && m_pend != 0; k++) step();

      clear = 1'b1;
      step();
      clear = 1'b0;
      guard = 0;
      while (!m_sat && guard < 1000) begin
         award(15);
         guard++;
      end
      check("sat_flag", 32'(saturated), 32'h1);
      check("sat_score", 32'(score_bcd), 32'h9999);
      check("sat_ready", 32'(add_ready), 32'h1);
      award(3);
      check("sat_hold", 32'(score_bcd), 32'h9999);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("sat_cleared", 32'(saturated), 32'h0);

      add_valid = 1'b1;
      add_points = 4'd9;
      step();
      add_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_score", 32'(score_bcd), 32'h0000);
      check("midrst_ready", 32'(add_ready), 32'h1);
      repeat (5) step();
      check("midrst_discard", 32'(score_bcd), 32'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
